// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multi-cycle control FSM for an RV32I core. Sequences
//            FETCH -> DECODE -> EXEC -> [MEM] -> [WB] over a shared datapath
//            with a single variable-latency memory port (req/ready).
// Ports    : i_clk, i_rst         clock, synchronous active-high reset
//            i_inst               instruction register contents
//            i_mem_ready          memory completes the current request
//            i_branch_taken       comparator result, meaningful in EXEC
//            o_mem_req/we/sel     memory request, store enable, address source
//            o_ir_we, o_pc_we     instruction register / PC load strobes
//            o_pc_sel             next PC: 00 PC+4, 01 PC+imm, 10 ALU & ~1
//            o_format             one-hot immediate format [0]R..[5]J
//            o_alu_a_sel/b_sel    ALU operand selects
//            o_rf_we, o_wb_sel    register write strobe / writeback source
//            o_retire             one-cycle pulse per completed instruction
//            o_halt, o_illegal    halted / halted on illegal opcode (sticky)
//            o_state              FSM state for debug
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst,
  input  logic        i_mem_ready,
  input  logic        i_branch_taken,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_mem_sel,
  output logic        o_ir_we,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic [5:0]  o_format,
  output logic [1:0]  o_alu_a_sel,
  output logic        o_alu_b_sel,
  output logic        o_rf_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_retire,
  output logic        o_halt,
  output logic        o_illegal,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic [6:0] opcode;
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic is_opimm, is_op, is_misc, is_system, is_illegal;
  logic unused_inst_hi;

  assign opcode    = i_inst[6:0];
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_misc   = (opcode == OPC_MISC);
  assign is_system = (opcode == OPC_SYSTEM);
  assign is_illegal = ~(is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                        is_store | is_opimm | is_op | is_misc | is_system);

  // Only the opcode field steers control; the rest of the word feeds the datapath.
  assign unused_inst_hi = ^i_inst[31:7];

  // Immediate format is decoded from the IR in every state.
  always_comb begin
    o_format = 6'b000001;
    if (is_lui | is_auipc)                               o_format = 6'b010000;
    else if (is_jal)                                     o_format = 6'b100000;
    else if (is_jalr | is_load | is_opimm | is_misc | is_system) o_format = 6'b000010;
    else if (is_branch)                                  o_format = 6'b001000;
    else if (is_store)                                   o_format = 6'b000100;
  end

  // Per-class ALU operand selects, driven in EXEC and held through MEM.
  logic [1:0] cls_a_sel;
  logic       cls_b_sel;
  assign cls_a_sel = is_lui ? 2'b10 : (is_auipc ? 2'b01 : 2'b00);
  assign cls_b_sel = is_lui | is_auipc | is_opimm | is_jalr | is_load | is_store;

  // Raw strobes before reset gating.
  logic mem_req_raw, mem_we_raw, ir_we_raw, pc_we_raw, rf_we_raw, retire_raw;

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    mem_req_raw = 1'b0;
    mem_we_raw  = 1'b0;
    ir_we_raw   = 1'b0;
    pc_we_raw   = 1'b0;
    rf_we_raw   = 1'b0;
    retire_raw  = 1'b0;
    o_mem_sel   = 1'b0;
    o_pc_sel    = 2'b00;
    o_alu_a_sel = 2'b00;
    o_alu_b_sel = 1'b0;
    o_wb_sel    = 2'b00;
    o_halt      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        if (i_mem_ready) begin
          ir_we_raw = 1'b1;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_system) begin
          state_d = S_HALT;
        end else if (is_illegal && HALT_ON_ILLEGAL) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        o_alu_a_sel = cls_a_sel;
        o_alu_b_sel = cls_b_sel;
        if (is_branch) begin
          pc_we_raw  = 1'b1;
          o_pc_sel   = i_branch_taken ? 2'b01 : 2'b00;
          retire_raw = 1'b1;
          state_d    = S_FETCH;
        end else if (is_jal) begin
          rf_we_raw  = 1'b1;
          o_wb_sel   = 2'b10;
          pc_we_raw  = 1'b1;
          o_pc_sel   = 2'b01;
          retire_raw = 1'b1;
          state_d    = S_FETCH;
        end else if (is_jalr) begin
          // rd gets the old PC+4: RF and PC are written on the same edge.
          rf_we_raw  = 1'b1;
          o_wb_sel   = 2'b10;
          pc_we_raw  = 1'b1;
          o_pc_sel   = 2'b10;
          retire_raw = 1'b1;
          state_d    = S_FETCH;
        end else if (is_load | is_store) begin
          state_d = S_MEM;
        end else if (is_op | is_opimm | is_lui | is_auipc) begin
          state_d = S_WB;
        end else begin
          // MISC-MEM, or an unknown opcode when not halting on it: retire as no-op.
          pc_we_raw  = 1'b1;
          retire_raw = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_MEM: begin
        mem_req_raw = 1'b1;
        mem_we_raw  = is_store;
        o_mem_sel   = 1'b1;
        o_alu_a_sel = cls_a_sel;
        o_alu_b_sel = cls_b_sel;
        if (i_mem_ready) begin
          if (is_store) begin
            pc_we_raw  = 1'b1;
            retire_raw = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we_raw  = 1'b1;
        o_wb_sel   = is_load ? 2'b01 : 2'b00;
        pc_we_raw  = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: begin
        o_halt = 1'b1;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset suppresses every strobe combinationally, so a reset landing in MEM
  // withdraws the request (and any store) in that very cycle.
  assign o_mem_req = mem_req_raw & ~i_rst;
  assign o_mem_we  = mem_we_raw  & ~i_rst;
  assign o_ir_we   = ir_we_raw   & ~i_rst;
  assign o_pc_we   = pc_we_raw   & ~i_rst;
  assign o_rf_we   = rf_we_raw   & ~i_rst;
  assign o_retire  = retire_raw  & ~i_rst;

  assign o_illegal = illegal_q;
  assign o_state   = state_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
`default_nettype wire
